// File: rtl/dm_prefetch_responder.sv
// In-order prefetch tracker: accepts {trace_index, mem_addr} requests, fetches each once, then retires them in order.
// Optional DM_RESPONDER_COALESCE_EN: a request whose address matches an occupied slot is retired without a fetch.
module dm_prefetch_responder #(
    parameter int DATA_ADDR_WIDTH   = 32,
    parameter int TRACE_INDEX_WIDTH = 17,
    parameter int TRACKER_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [DATA_ADDR_WIDTH-1:0]           req_mem_addr,
    input  logic [TRACE_INDEX_WIDTH-1:0]         req_trace_index,
    output logic                                 ret_valid,
    input  logic                                 ret_ready,
    output logic [TRACE_INDEX_WIDTH-1:0]         ret_trace_index,
    output logic [DATA_ADDR_WIDTH-1:0]           ret_mem_addr,
    output logic                                 mem_req,
    input  logic                                 mem_gnt,
    output logic [DATA_ADDR_WIDTH-1:0]           mem_addr,
    input  logic                                 mem_rvalid,
    output logic [$clog2(TRACKER_DEPTH):0]       occupancy
);

    localparam int PW = $clog2(TRACKER_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1'b1);
    localparam logic [OW-1:0] OCC_FULL = OW'(TRACKER_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    state_t                         state_r;
    state_t                         next_state_s;
    logic                           occ_r   [TRACKER_DEPTH];
    logic                           proc_r  [TRACKER_DEPTH];
    logic                           skip_r  [TRACKER_DEPTH];
    logic [DATA_ADDR_WIDTH-1:0]     addr_r  [TRACKER_DEPTH];
    logic [TRACE_INDEX_WIDTH-1:0]   index_r [TRACKER_DEPTH];
    logic [PW-1:0]                  hd_r;
    logic [PW-1:0]                  tl_r;
    logic                           accept_s;
    logic                           retire_fire_s;
    logic                           start_issue_s;
    logic                           enter_retire_s;
    logic                           match_s;

    // Ready depends only on registered occupancy; a same-cycle retirement does not open a slot early.
    assign req_ready = (occupancy != OCC_FULL);
    assign accept_s  = req_valid && req_ready;

`ifdef DM_RESPONDER_COALESCE_EN
    // Address match against occupied slots, excluding the head slot being freed this cycle.
    always_comb begin
        match_s = 1'b0;
        for (int i = 0; i < TRACKER_DEPTH; i++) begin
            match_s = match_s | (occ_r[i] && !(retire_fire_s && (hd_r == PW'(i)))
                                 && (addr_r[i] == req_mem_addr));
        end
    end
`else
    // Coalescing disabled: every request fetches.
    always_comb begin
        match_s = 1'b0;
    end
`endif

    // Issue FSM next-state decode on the head slot.
    always_comb begin
        next_state_s   = state_r;
        start_issue_s  = 1'b0;
        retire_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (occ_r[hd_r] && skip_r[hd_r]) begin
                    next_state_s = ST_RETIRE;
                end else if (occ_r[hd_r] && !proc_r[hd_r]) begin
                    next_state_s  = ST_ISSUE;
                    start_issue_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    next_state_s = ST_RETIRE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RETIRE: begin
                if (ret_ready) begin
                    next_state_s  = ST_IDLE;
                    retire_fire_s = 1'b1;
                end else begin
                    next_state_s = ST_RETIRE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        enter_retire_s = (state_r != ST_RETIRE) && (next_state_s == ST_RETIRE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Tracker slots, pointers and occupancy; allocation and free never target the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TRACKER_DEPTH; i++) begin
                occ_r[i]   <= 1'b0;
                proc_r[i]  <= 1'b0;
                skip_r[i]  <= 1'b0;
                addr_r[i]  <= {DATA_ADDR_WIDTH{1'b0}};
                index_r[i] <= {TRACE_INDEX_WIDTH{1'b0}};
            end
            hd_r      <= {PW{1'b0}};
            tl_r      <= {PW{1'b0}};
            occupancy <= {OW{1'b0}};
        end else begin
            if (accept_s) begin
                occ_r[tl_r]   <= 1'b1;
                proc_r[tl_r]  <= 1'b0;
                skip_r[tl_r]  <= match_s;
                addr_r[tl_r]  <= req_mem_addr;
                index_r[tl_r] <= req_trace_index;
                tl_r          <= tl_r + PTR_ONE;
            end
            if (start_issue_s) begin
                proc_r[hd_r] <= 1'b1;
            end
            if (retire_fire_s) begin
                occ_r[hd_r]   <= 1'b0;
                proc_r[hd_r]  <= 1'b0;
                skip_r[hd_r]  <= 1'b0;
                addr_r[hd_r]  <= {DATA_ADDR_WIDTH{1'b0}};
                index_r[hd_r] <= {TRACE_INDEX_WIDTH{1'b0}};
                hd_r          <= hd_r + PTR_ONE;
            end
            case ({accept_s, retire_fire_s})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Registered memory and retirement outputs, captured on state entry so they hold stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req         <= 1'b0;
            mem_addr        <= {DATA_ADDR_WIDTH{1'b0}};
            ret_valid       <= 1'b0;
            ret_trace_index <= {TRACE_INDEX_WIDTH{1'b0}};
            ret_mem_addr    <= {DATA_ADDR_WIDTH{1'b0}};
        end else begin
            mem_req   <= (next_state_s == ST_ISSUE);
            ret_valid <= (next_state_s == ST_RETIRE);
            if (start_issue_s) begin
                mem_addr <= addr_r[hd_r];
            end
            if (enter_retire_s) begin
                ret_trace_index <= index_r[hd_r];
                ret_mem_addr    <= addr_r[hd_r];
            end
        end
    end

endmodule

// File: tb/tb_dm_prefetch_responder.sv
// Directed testbench for dm_prefetch_responder with a small memory responder and retirement monitor.
module tb_dm_prefetch_responder;

    localparam int AW = 32;
    localparam int IW = 17;
    localparam int D  = 4;
`ifdef DM_RESPONDER_COALESCE_EN
    localparam int EXP_FETCH = 1;
`else
    localparam int EXP_FETCH = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_mem_addr;
    logic [IW-1:0] req_trace_index;
    logic          ret_valid;
    logic          ret_ready;
    logic [IW-1:0] ret_trace_index;
    logic [AW-1:0] ret_mem_addr;
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid;
    logic [2:0]    occupancy;

    logic          auto_gnt  = 1'b0;
    logic          auto_rv   = 1'b0;
    logic          manual_rv = 1'b0;
    logic          mem_en    = 1'b0;
    int            gnt_delay = 2;
    int            rv_delay  = 3;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            phase    = 0;
    int            cnt      = 0;
    int            fetch_cnt = 0;
    int            rv_cyc   = 0;
    int            ret_cyc  = 0;
    logic [AW-1:0] fetch_q    [$];
    logic [IW-1:0] ret_idx_q  [$];
    logic [AW-1:0] ret_addr_q [$];

    assign mem_gnt    = auto_gnt;
    assign mem_rvalid = auto_rv | manual_rv;

    dm_prefetch_responder #(
        .DATA_ADDR_WIDTH(AW),
        .TRACE_INDEX_WIDTH(IW),
        .TRACKER_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mem_addr(req_mem_addr), .req_trace_index(req_trace_index),
        .ret_valid(ret_valid), .ret_ready(ret_ready),
        .ret_trace_index(ret_trace_index), .ret_mem_addr(ret_mem_addr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grant gnt_delay cycles after mem_req is seen, data rv_delay cycles after grant.
    always @(negedge clk) begin
        auto_gnt = 1'b0;
        auto_rv  = 1'b0;
        if (rst || !mem_en) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (mem_req) begin
                    fetch_cnt++;
                    fetch_q.push_back(mem_addr);
                    cnt   = 0;
                    phase = 1;
                end
                1: begin
                    cnt++;
                    if (cnt >= gnt_delay) begin
                        auto_gnt = 1'b1;
                        cnt      = 0;
                        phase    = 2;
                    end
                end
                2: begin
                    cnt++;
                    if (cnt >= rv_delay) begin
                        auto_rv = 1'b1;
                        rv_cyc  = cyc;
                        phase   = 0;
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    // Retirement monitor.
    always @(negedge clk) begin
        if (!rst && ret_valid && ret_ready) begin
            ret_idx_q.push_back(ret_trace_index);
            ret_addr_q.push_back(ret_mem_addr);
            ret_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [AW-1:0] addr);
        int t;
        t = 0;
        req_valid       = 1'b1;
        req_trace_index = IW'(idx);
        req_mem_addr    = addr;
        @(negedge clk);
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("send_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ret(input int n, input int bound);
        int t;
        t = 0;
        while (ret_idx_q.size() < n && t < bound) begin
            tick();
            t++;
        end
        check("ret_count", 64'(ret_idx_q.size()), 64'(n));
    endtask

    initial begin
        int base;
        int fbase;
        int t;
        rst = 1'b1; req_valid = 1'b0; ret_ready = 1'b0;
        req_mem_addr = '0; req_trace_index = '0;
        repeat (3) tick();
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_outputs", {ret_valid, mem_req, occupancy}, 64'(0));
        check("rst_fields", {ret_trace_index, ret_mem_addr, mem_addr}, 64'(0));
        rst = 1'b0;
        tick();

        // Single request with latency checks
        mem_en = 1'b1; ret_ready = 1'b1; gnt_delay = 2; rv_delay = 3;
        base = ret_idx_q.size(); fbase = fetch_cnt;
        send(5, 32'h0000_1000);
        check("lat_n1_mem_req", 64'(mem_req), 64'(0));
        check("lat_n1_occ", 64'(occupancy), 64'(1));
        tick();
        check("lat_n2_mem_req", 64'(mem_req), 64'(1));
        check("lat_n2_mem_addr", 64'(mem_addr), 64'h1000);
        wait_ret(base + 1, 50);
        check("single_occ", 64'(occupancy), 64'(0));
        check("single_ret", {ret_idx_q[base], ret_addr_q[base]}, {17'd5, 32'h0000_1000});
        check("single_fetch_cnt", 64'(fetch_cnt - fbase), 64'(1));
        check("single_fetch_addr", 64'(fetch_q[fbase]), 64'h1000);
        check("single_ret_lat", 64'(ret_cyc - rv_cyc), 64'(1));

        // Fill to full with grants held off
        repeat (3) tick();
        mem_en = 1'b0;
        base = ret_idx_q.size();
        for (int k = 0; k < 4; k++) send(k, 32'h0000_5000 + 32'(k * 16));
        check("full_occ", 64'(occupancy), 64'(4));
        check("full_ready", 64'(req_ready), 64'(0));
        req_valid = 1'b1; req_trace_index = 17'd4; req_mem_addr = 32'h0000_5040;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("full_hold", {occupancy, req_ready}, {3'd4, 1'b0});
        end
        mem_en = 1'b1;
        t = 0;
        while (occupancy == 3'd4 && t < 100) begin
            tick();
            t++;
        end
        check("drop_occ", 64'(occupancy), 64'(3));
        check("drop_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        check("refill_occ", 64'(occupancy), 64'(4));
        wait_ret(base + 5, 300);
        for (int k = 0; k < 5; k++)
            check("fill_order", {ret_idx_q[base + k], ret_addr_q[base + k]},
                  {17'(k), 32'h0000_5000 + 32'(k * 16)});

        // Retirement backpressure
        ret_ready = 1'b0;
        base = ret_idx_q.size(); fbase = fetch_cnt;
        send(9, 32'h0000_3000);
        send(10, 32'h0000_3100);
        t = 0;
        while (!ret_valid && t < 50) begin
            tick();
            t++;
        end
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {ret_valid, mem_req, ret_trace_index, ret_mem_addr},
                  {1'b1, 1'b0, 17'd9, 32'h0000_3000});
            tick();
        end
        check("bp_fetch_cnt", 64'(fetch_cnt - fbase), 64'(1));
        ret_ready = 1'b1;
        wait_ret(base + 2, 100);
        check("bp_order", {ret_idx_q[base], ret_idx_q[base + 1]}, {17'd9, 17'd10});

        // Pointer wrap-around
        base = ret_idx_q.size();
        for (int k = 0; k < 10; k++) send(100 + k, 32'h0000_4000 + 32'(k * 64));
        wait_ret(base + 10, 600);
        for (int k = 0; k < 10; k++)
            check("wrap_order", {ret_idx_q[base + k], ret_addr_q[base + k]},
                  {17'(100 + k), 32'h0000_4000 + 32'(k * 64)});
        check("wrap_occ", 64'(occupancy), 64'(0));

        // Coalescing of identical addresses
        base = ret_idx_q.size(); fbase = fetch_cnt;
        send(7, 32'h0000_2000);
        send(8, 32'h0000_2000);
        wait_ret(base + 2, 100);
        repeat (5) tick();
        check("coal_fetch_cnt", 64'(fetch_cnt - fbase), 64'(EXP_FETCH));
        check("coal_order", {ret_idx_q[base], ret_idx_q[base + 1]}, {17'd7, 17'd8});

        // Reset while waiting for data
        rv_delay = 40;
        base = ret_idx_q.size();
        send(20, 32'h0000_6000);
        t = 0;
        while (!mem_req && t < 20) begin tick(); t++; end
        while (mem_req && t < 40) begin tick(); t++; end
        check("wait_reached", {mem_req, occupancy}, {1'b0, 3'd1});
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_en = 1'b0; manual_rv = 1'b1;
        tick();
        manual_rv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rst_no_ret", 64'(ret_valid), 64'(0));
            tick();
        end
        check("rst_state", {occupancy, req_ready, mem_req}, {3'd0, 1'b1, 1'b0});
        check("rst_no_retire", 64'(ret_idx_q.size()), 64'(base));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_prefetch_responder.md
# dm_prefetch_responder

Cache-side responder for trace-repository prefetch requests. Accepts `{trace_index, mem_addr}` requests issued during the repository's MAKE_REQUEST phase and holds them in an in-order tracker buffer. Performs one memory fetch per entry into the direct-mapped cache fill path, then returns a retirement handshake that moves the repository entry from WAIT_FOR_PROCESSING to REQUEST_RETIRED.

## Interface
Parameters:
- `DATA_ADDR_WIDTH`, 32: memory address width.
- `TRACE_INDEX_WIDTH`, 17: trace index width, equal to log2 of 131072 trace entries.
- `TRACKER_DEPTH`, 4: tracker slots; must be a power of two and at least 2.

Ports. Clock is `clk`; reset is `rst`, synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_mem_addr` in DATA_ADDR_WIDTH: address to prefetch.
- `req_trace_index` in TRACE_INDEX_WIDTH: originating trace entry.
- `ret_valid` out 1: retirement present.
- `ret_ready` in 1: retirement consumed.
- `ret_trace_index` out TRACE_INDEX_WIDTH: trace index of the retired entry.
- `ret_mem_addr` out DATA_ADDR_WIDTH: address of the retired entry.
- `mem_req` out 1: fetch request to memory.
- `mem_gnt` in 1: memory grant.
- `mem_addr` out DATA_ADDR_WIDTH: fetch address.
- `mem_rvalid` in 1: fetch data returned.
- `occupancy` out $clog2(TRACKER_DEPTH)+1: number of occupied slots.

## Operation
- Tracker: a circular buffer of slots `{occupied, processing, skip, mem_addr, trace_index}` with head pointer `hd` and tail pointer `tl`, each $clog2(TRACKER_DEPTH) bits wide. Both pointers wrap modulo TRACKER_DEPTH.
- Allocation:
  - `req_ready = (occupancy != TRACKER_DEPTH)`. It is purely a function of registered state and has no bypass from same-cycle retirement.
  - On accept, write slot[tl] with `occupied=1`, `processing=0`, and the request fields, then increment tl.
- Issue FSM, operating on slot[hd]:
  - IDLE → RETIRE if slot[hd] is occupied and skip=1.
  - IDLE → ISSUE if slot[hd] is occupied and skip=0; set `processing=1`.
  - ISSUE: `mem_req=1`, `mem_addr=slot[hd].mem_addr`, held stable until `mem_gnt`. On `mem_gnt` → WAIT.
  - WAIT: `mem_req=0`. On `mem_rvalid` → RETIRE.
  - RETIRE: `ret_valid=1`; `ret_trace_index` and `ret_mem_addr` come from slot[hd] and are held stable until `ret_ready`. On `ret_ready`: clear slot[hd], increment hd, → IDLE.
- Exactly one memory transaction is outstanding at a time. Retirement order equals acceptance order.
- `mem_rvalid` is ignored in every state except WAIT.
- `mem_gnt` in the same cycle as the ISSUE entry is not possible, because `mem_req` is registered.
- Occupancy:
  - Accept alone: +1. Retire alone: −1. Both in the same cycle: unchanged.
  - Accept-while-full cannot occur, since `req_ready` is low.
  - Retire-while-empty cannot occur, since the FSM only leaves IDLE on an occupied slot.
- Arithmetic: `occupancy` is one bit wider than the pointers, so the full value TRACKER_DEPTH is representable without aliasing.

## Timing
- Reset values: `req_ready=1`, `ret_valid=0`, `ret_trace_index=0`, `ret_mem_addr=0`, `mem_req=0`, `mem_addr=0`, `occupancy=0`. FSM=IDLE, all slots cleared, hd=tl=0.
- All outputs are registered except `req_ready`, which is decoded from the registered occupancy.
- Latency: with the buffer empty, a request accepted at cycle N gives IDLE→ISSUE at N+1 and `mem_req=1` from N+2.
- A grant at cycle G gives `ret_valid` at R+1, where R is the `mem_rvalid` cycle.
- Slot freed and `occupancy` decremented at the cycle after the `ret_valid && ret_ready` cycle.
- Reset mid-operation: all state is cleared in the next cycle. A pending `mem_rvalid` arriving after reset is dropped because FSM=IDLE. No retirement is generated for discarded entries.

## Configuration
- `DM_RESPONDER_COALESCE_EN` defined:
  - On accept, `req_mem_addr` is compared against every occupied slot, including one in ISSUE or WAIT.
  - On a match, the slot is written with `skip=1` and is retired without a memory fetch, reaching RETIRE the cycle after it becomes head.
  - The comparison ignores slots being freed in the same cycle.
- Undefined: `skip` is tied to 0, no compare logic is built, and every request fetches.

## Test plan
- Single request: addr 0x0000_1000, index 5, `mem_gnt` 2 cycles after `mem_req`, `mem_rvalid` 3 cycles after grant.
  - Required: exactly one `mem_req`/`mem_gnt` pair with `mem_addr=0x1000`, then `ret_valid` with index 5 and addr 0x1000, then `occupancy` returns to 0.
- Fill to full: 5 back-to-back requests, indices 0–4, with `mem_gnt` held low.
  - Required: first 4 accepted; `req_ready=0` and `occupancy=4` until the first retirement; the 5th is accepted the cycle after `occupancy` drops to 3.
- Backpressure: `ret_ready=0` for 10 cycles in RETIRE.
  - Required: `ret_valid`, `ret_trace_index` and `ret_mem_addr` stable; no new `mem_req` issued.
- Pointer wrap-around: 10 sequential requests, indices 100–109, with `ret_ready=1`.
  - Required: retirements in order 100–109 with matching addresses.
- Coalescing: with `DM_RESPONDER_COALESCE_EN` defined, send addr 0x2000 twice (indices 7 and 8).
  - Required: one memory fetch; two retirements, 7 then 8.
  - With the macro undefined: two fetches.
- Reset during WAIT: assert `rst` for one cycle, then pulse `mem_rvalid`.
  - Required: no `ret_valid`, `occupancy=0`, `req_ready=1`.
